// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam int P_CORE = 0;
  localparam int P_DMA  = 1;

endpackage

// File: rtl/dmem_arb_grant.sv
// Grant FSM: picks at most one requester per cycle and bounds how long an
// owner keeps the memory while the other port waits.
module dmem_arb_grant
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] burst_cnt, cnt_nxt;
  logic             keep;

  // Grant decision, next owner and burst count.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    state_nxt = IDLE;
    cnt_nxt   = {CNT_W{1'b0}};
    keep      = (burst_cnt < CNT_MAX);
    if (rst_n) begin
      if (req0 && req1) begin
        case (state)
          OWN0: begin
            if (keep) gnt0 = 1'b1;
            else      gnt1 = 1'b1;
          end
          OWN1: begin
            if (keep) gnt1 = 1'b1;
            else      gnt0 = 1'b1;
          end
          default: gnt0 = 1'b1;
        endcase
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
      // The count only grows while the same owner is re-granted under contention.
      if (gnt0) begin
        state_nxt = OWN0;
        if (state == OWN0 && req1) begin
          cnt_nxt = (burst_cnt == CNT_MAX) ? CNT_MAX : burst_cnt + 1'b1;
        end else begin
          cnt_nxt = {CNT_W{1'b0}};
        end
      end else if (gnt1) begin
        state_nxt = OWN1;
        if (state == OWN1 && req0) begin
          cnt_nxt = (burst_cnt == CNT_MAX) ? CNT_MAX : burst_cnt + 1'b1;
        end else begin
          cnt_nxt = {CNT_W{1'b0}};
        end
      end else begin
        state_nxt = IDLE;
        cnt_nxt   = {CNT_W{1'b0}};
      end
    end else begin
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      state_nxt = IDLE;
      cnt_nxt   = {CNT_W{1'b0}};
    end
  end

  // Owner and burst count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      burst_cnt <= {CNT_W{1'b0}};
    end else begin
      state     <= state_nxt;
      burst_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core LSU on port 0, DMA/debug on port 1.
// Optional address checking is enabled by defining DMEM_ARBITER_CHK_EN.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4,
  parameter int MEM_WORDS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rerr,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rerr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0] gnt;
  logic [1:0] err;

  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    return (a[1:0] != 2'b00) ||
           ({2'b00, a[ADDR_W-1:2]} >= ADDR_W'(MEM_WORDS));
  endfunction

  dmem_arb_grant #(.MAX_BURST(MAX_BURST)) u_grant (
    .clk   (clk),
    .rst_n (rst_n),
    .req0  (m0_req),
    .req1  (m1_req),
    .gnt0  (gnt[P_CORE]),
    .gnt1  (gnt[P_DMA])
  );

  assign m0_gnt = gnt[P_CORE];
  assign m1_gnt = gnt[P_DMA];

`ifdef DMEM_ARBITER_CHK_EN
  assign err[P_CORE] = addr_bad(m0_addr);
  assign err[P_DMA]  = addr_bad(m1_addr);
`else
  assign err = 2'b00;
`endif

  // Route the granted port to the memory; erroneous accesses never write.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    if (gnt[P_CORE]) begin
      mem_we    = m0_we & ~err[P_CORE];
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (gnt[P_DMA]) begin
      mem_we    = m1_we & ~err[P_DMA];
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end else begin
      mem_we    = 1'b0;
      mem_addr  = {ADDR_W{1'b0}};
      mem_wdata = {DATA_W{1'b0}};
    end
  end

  // One-cycle response registers; writes and errors return zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rvalid <= 1'b0;
      m0_rdata  <= {DATA_W{1'b0}};
      m0_rerr   <= 1'b0;
      m1_rvalid <= 1'b0;
      m1_rdata  <= {DATA_W{1'b0}};
      m1_rerr   <= 1'b0;
    end else begin
      m0_rvalid <= gnt[P_CORE];
      m0_rerr   <= gnt[P_CORE] & err[P_CORE];
      m0_rdata  <= (gnt[P_CORE] && !m0_we && !err[P_CORE]) ? mem_rdata : {DATA_W{1'b0}};
      m1_rvalid <= gnt[P_DMA];
      m1_rerr   <= gnt[P_DMA] & err[P_DMA];
      m1_rdata  <= (gnt[P_DMA] && !m1_we && !err[P_DMA]) ? mem_rdata : {DATA_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural 64-word data memory.
module tb_dmem_arbiter;

  localparam int MAX_BURST = 4;
`ifdef DMEM_ARBITER_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid, m0_rerr;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_rerr;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] phys_mem [0:63];
  logic [31:0] ref_mem  [0:63];
  logic [32:0] q0[$], q1[$];

  int   n_cmp = 0, n_err = 0;
  int   own = -1, run = 0;
  logic mg0, mg1, obs_g0, obs_g1, obs_rv1;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MAX_BURST), .MEM_WORDS(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rerr(m0_rerr),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rerr(m1_rerr),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] seed(input int i);
    return (i == 4) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i) * 32'h0000_0101;
  endfunction

  function automatic logic bad(input logic [31:0] a);
    return CHK && ((a[1:0] != 2'b00) || (a[31:2] >= 30'd64));
  endfunction

  // Memory is reloaded with its seed pattern whenever reset is held.
  assign mem_rdata = phys_mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) phys_mem[i] <= seed(i);
    end else if (mem_we) begin
      phys_mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d;
  endtask

  task automatic set1(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d;
  endtask

  task automatic model_reset();
    own = -1; run = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = seed(i);
    q0.delete(); q1.delete();
  endtask

  // One clock cycle: predict grant, push expected response, check it after the edge.
  task automatic step();
    logic        g0, g1, b0, b1;
    logic [31:0] ea;
    logic [32:0] e;
    int          w;
    #1;
    b0 = bad(m0_addr);
    b1 = bad(m1_addr);
    g0 = 1'b0; g1 = 1'b0;
    if (m0_req && m1_req) begin
      if (own < 0)              g0 = 1'b1;
      else if (run < MAX_BURST) begin if (own == 0) g0 = 1'b1; else g1 = 1'b1; end
      else                      begin if (own == 0) g1 = 1'b1; else g0 = 1'b1; end
    end else begin
      g0 = m0_req; g1 = m1_req;
    end
    obs_g0 = m0_gnt; obs_g1 = m1_gnt;
    check_eq("gnt0", m0_gnt, g0);
    check_eq("gnt1", m1_gnt, g1);
    check_eq("mem_we", mem_we, (g0 & m0_we & ~b0) | (g1 & m1_we & ~b1));
    ea = g0 ? m0_addr : (g1 ? m1_addr : 32'h0);
    check_eq("mem_addr", mem_addr, ea);
    if (g0) begin
      q0.push_back({b0, (m0_we || b0) ? 32'h0 : ref_mem[m0_addr[7:2]]});
      if (m0_we && !b0) ref_mem[m0_addr[7:2]] = m0_wdata;
    end
    if (g1) begin
      q1.push_back({b1, (m1_we || b1) ? 32'h0 : ref_mem[m1_addr[7:2]]});
      if (m1_we && !b1) ref_mem[m1_addr[7:2]] = m1_wdata;
    end
    if (g0 || g1) begin
      w = g0 ? 0 : 1;
      if (w == own && (g0 ? m1_req : m0_req)) run++;
      else run = 1;
      own = w;
    end else begin
      own = -1; run = 0;
    end
    mg0 = g0; mg1 = g1;
    @(posedge clk); #1;
    check_eq("rvalid0", m0_rvalid, g0);
    check_eq("rvalid1", m1_rvalid, g1);
    obs_rv1 = m1_rvalid;
    if (g0 && q0.size() > 0) begin
      e = q0.pop_front();
      check_eq("rdata0", m0_rdata, e[31:0]);
      check_eq("rerr0", m0_rerr, e[32]);
    end
    if (g1 && q1.size() > 0) begin
      e = q1.pop_front();
      check_eq("rdata1", m1_rdata, e[31:0]);
      check_eq("rerr1", m1_rerr, e[32]);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [9:0] pat;
    int         pulses;
    rst_n = 1'b0;
    set0(1'b1, 1'b1, 32'h10, 32'h1); set1(1'b1, 1'b1, 32'h14, 32'h2);
    #1;
    check_eq("rst_gnt0", m0_gnt, 1'b0);
    check_eq("rst_gnt1", m1_gnt, 1'b0);
    check_eq("rst_mem_we", mem_we, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    check_eq("rst_rvalid0", m0_rvalid, 1'b0);
    check_eq("rst_rvalid1", m1_rvalid, 1'b0);
    check_eq("rst_rdata0", m0_rdata, 32'h0);
    check_eq("rst_rerr1", m1_rerr, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    set0(1'b0, 1'b0, 32'h0, 32'h0); set1(1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Single read of a preloaded word.
    set0(1'b1, 1'b0, 32'h10, 32'h0);
    step();
    check_eq("t1_rdata", m0_rdata, 32'hDEADBEEF);
    set0(1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Continuous contention from IDLE.
    pat = 10'b0011110000;
    set0(1'b1, 1'b0, 32'h10, 32'h0); set1(1'b1, 1'b0, 32'h14, 32'h0);
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("t2_order", obs_g1, pat[i]);
      check_eq("t2_excl", obs_g0 & obs_g1, 1'b0);
    end
    set0(1'b0, 1'b0, 32'h0, 32'h0); set1(1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Write from port 1 followed by a read from port 0.
    set1(1'b1, 1'b1, 32'h20, 32'h12345678);
    step();
    set1(1'b0, 1'b0, 32'h0, 32'h0);
    set0(1'b1, 1'b0, 32'h20, 32'h0);
    step();
    check_eq("t3_rdata", m0_rdata, 32'h12345678);
    set0(1'b0, 1'b0, 32'h0, 32'h0);

    // Port 1 alone for ten cycles.
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      set1(1'b1, 1'b0, 32'(i) << 2, 32'h0);
      step();
      if (obs_rv1) pulses++;
    end
    check_eq("t4_pulses", pulses, 10);
    set1(1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Reset arriving during a granted write.
    set1(1'b1, 1'b1, 32'h18, 32'h5555AAAA);
    #1;
    check_eq("t5_pre_gnt1", m1_gnt, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("t5_gnt1", m1_gnt, 1'b0);
    check_eq("t5_mem_we", mem_we, 1'b0);
    set0(1'b1, 1'b0, 32'h8, 32'h0);
    set1(1'b1, 1'b0, 32'hC, 32'h0);
    @(posedge clk); #1;
    check_eq("t5_rvalid1", m1_rvalid, 1'b0);
    check_eq("t5_rvalid0", m0_rvalid, 1'b0);
    check_eq("t5_gnt0", m0_gnt, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step();
    check_eq("t5_tie", obs_g0, 1'b1);
    set0(1'b0, 1'b0, 32'h0, 32'h0); set1(1'b0, 1'b0, 32'h0, 32'h0);
    step();

`ifdef DMEM_ARBITER_CHK_EN
    // Misaligned and out-of-range writes.
    set0(1'b1, 1'b1, 32'h102, 32'hCAFEF00D);
    step();
    check_eq("t6a_rerr", m0_rerr, 1'b1);
    check_eq("t6a_rdata", m0_rdata, 32'h0);
    set0(1'b1, 1'b1, 32'h100, 32'hCAFEF00D);
    step();
    check_eq("t6b_rerr", m0_rerr, 1'b1);
    check_eq("t6b_rdata", m0_rdata, 32'h0);
    set0(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    check_eq("t6_mem0", phys_mem[0], seed(0));
`endif

    // Random mixed traffic; a port only changes its request once granted.
    for (int c = 0; c < 300; c++) begin
      if (!m0_req || mg0) begin
        if ($urandom_range(0, 3) != 0)
          set0(1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom);
        else
          set0(1'b0, 1'b0, 32'h0, 32'h0);
      end
      if (!m1_req || mg1) begin
        if ($urandom_range(0, 3) != 0)
          set1(1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom);
        else
          set1(1'b0, 1'b0, 32'h0, 32'h0);
      end
      step();
    end
    set0(1'b0, 1'b0, 32'h0, 32'h0); set1(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    for (int i = 0; i < 16; i++) check_eq("final_mem", phys_mem[i], ref_mem[i]);
    check_eq("q_empty", 32'(q0.size() + q1.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
